fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS pipeline. It is the consumer of the ID-stage control outputs `cu_wpcir`, `cu_branch` and `cu_jump`. It owns the PC, talks to instruction memory over a req/ack handshake with arbitrary wait states, computes branch and jump targets, and supplies both the in-flight IF word (`if_instr`) and the ID-stage instruction (`id_instr`) to the control unit.

---
 rtl/mips_pkg.sv | 19 +
 rtl/branch_target_gen.sv | 25 ++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   fetch_state_e : states of the instruction-fetch FSM
//   OP_*          : primary opcodes of the control-flow instructions
//   NOP_INSTR     : all-zero word (sll $0,$0,0) used as a pipeline bubble
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_e;

  localparam logic [5:0]  OP_JMP    = 6'h02;
  localparam logic [5:0]  OP_BEQ    = 6'h04;
  localparam logic [5:0]  OP_BNE    = 6'h05;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/branch_target_gen.sv
// Redirect target generator for the instruction in ID.
//   i_pc4       : PC+4 of the instruction in ID
//   i_instr_idx : low 26 bits of the ID instruction (imm16 / jump index)
//   i_jump      : 1 = select the j target, 0 = select the branch target
//   o_target    : resulting fetch address
module branch_target_gen
  import mips_pkg::*;
(
  input  logic [31:0] i_pc4,
  input  logic [25:0] i_instr_idx,
  input  logic        i_jump,
  output logic [31:0] o_target
);

  logic signed [31:0] w_offset;
  logic        [31:0] w_br_target;
  logic        [31:0] w_jmp_target;

  // Sign-extended word offset; the add wraps modulo 2^32.
  assign w_offset     = {{14{i_instr_idx[15]}}, i_instr_idx[15:0], 2'b00};
  assign w_br_target  = i_pc4 + $unsigned(w_offset);
  assign w_jmp_target = {i_pc4[31:28], i_instr_idx, 2'b00};
  assign o_target     = i_jump ? w_jmp_target : w_br_target;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Owns the PC, fetches over a req/ack handshake with arbitrary wait states,
// applies load-use stalls and taken redirects (no delay slot).
//   clk, rst            : clock, asynchronous active-low reset
//   cu_wpcir            : stall, hold PC and IF/ID
//   cu_branch, cu_jump  : taken redirect / redirect is a j
//   imem_req/addr       : fetch request and word address (registered)
//   imem_ack/rdata      : one-cycle acknowledge with data
//   if_instr            : word currently in IF (combinational)
//   id_instr/pc4/valid  : IF/ID register
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cu_wpcir,
  input  logic        cu_branch,
  input  logic        cu_jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  import mips_pkg::*;

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_buf, w_buf_nxt;
  logic [31:0]  r_id_instr, w_id_instr_nxt;
  logic [31:0]  r_id_pc4, w_id_pc4_nxt;
  logic         r_id_valid, w_id_valid_nxt;
  logic         r_req;
  logic [31:0]  r_addr;
  logic [31:0]  w_pc4;
  logic [31:0]  w_target;
  logic         w_ack;
  logic         w_redirect;

  branch_target_gen u_btg (
    .i_pc4       (r_id_pc4),
    .i_instr_idx (r_id_instr[25:0]),
    .i_jump      (cu_jump),
    .o_target    (w_target)
  );

  assign w_pc4      = r_pc + 32'd4;
  // Acks arriving with no request outstanding are ignored.
  assign w_ack      = imem_ack & r_req;
  // A stall wins over a redirect; the branch is re-evaluated next cycle.
  assign w_redirect = cu_branch & ~cu_wpcir;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_buf_nxt      = r_buf;
    w_id_instr_nxt = r_id_instr;
    w_id_pc4_nxt   = r_id_pc4;
    w_id_valid_nxt = r_id_valid;
    case (r_state)
      BOOT: w_state_nxt = REQ;
      REQ: begin
        if (cu_wpcir) begin
          if (w_ack) begin
            w_buf_nxt   = imem_rdata;
            w_state_nxt = HOLD;
          end
        end else if (w_redirect) begin
          w_pc_nxt       = w_target;
          w_id_instr_nxt = NOP_INSTR;
          w_id_valid_nxt = 1'b0;
          // Without ack the old request must still complete, so it is killed.
          w_state_nxt    = w_ack ? REQ : KILL;
        end else if (w_ack) begin
          w_id_instr_nxt = imem_rdata;
          w_id_pc4_nxt   = w_pc4;
          w_id_valid_nxt = 1'b1;
          w_pc_nxt       = w_pc4;
        end else begin
          w_id_instr_nxt = NOP_INSTR;
          w_id_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (!cu_wpcir) begin
          if (w_redirect) begin
            w_pc_nxt       = w_target;
            w_id_instr_nxt = NOP_INSTR;
            w_id_valid_nxt = 1'b0;
          end else begin
            w_id_instr_nxt = r_buf;
            w_id_pc4_nxt   = w_pc4;
            w_id_valid_nxt = 1'b1;
            w_pc_nxt       = w_pc4;
          end
          w_state_nxt = REQ;
        end
      end
      KILL: begin
        if (cu_wpcir) begin
          if (w_ack) w_state_nxt = REQ;
        end else begin
          w_id_instr_nxt = NOP_INSTR;
          w_id_valid_nxt = 1'b0;
          if (w_redirect) w_pc_nxt = w_target;
          else if (w_ack) w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_buf      <= 32'h0;
      r_id_instr <= NOP_INSTR;
      r_id_pc4   <= 32'h0;
      r_id_valid <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_buf      <= w_buf_nxt;
      r_id_instr <= w_id_instr_nxt;
      r_id_pc4   <= w_id_pc4_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_req      <= (w_state_nxt == REQ) || (w_state_nxt == KILL);
      // KILL keeps presenting the abandoned address until its ack.
      if (w_state_nxt == REQ) r_addr <= w_pc_nxt;
    end
  end

  always_comb begin
    if_instr = NOP_INSTR;
    if (r_state == REQ && w_ack) if_instr = imem_rdata;
    else if (r_state == HOLD)    if_instr = r_buf;
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign id_instr  = r_id_instr;
  assign id_pc4    = r_id_pc4;
  assign id_valid  = r_id_valid;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cu_wpcir, cu_branch, cu_jump;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, if_instr, id_instr, id_pc4;
  logic        id_valid;

  logic        h_branch, h_jump, h_req, h_ack, h_valid;
  logic [31:0] h_addr, h_rdata, h_if_instr, h_instr, h_pc4;

  logic [7:0]  mem_wait;
  logic [7:0]  wcnt;
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc4 = 32'h0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_001C) return 32'h1000_FFFF;
    if (a == 32'h3000_000C) return 32'h0800_0040;
    return a ^ 32'hC0DE_0000;
  endfunction

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .cu_wpcir(cu_wpcir), .cu_branch(cu_branch),
    .cu_jump(cu_jump), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_instr(if_instr),
    .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid)
  );

  // Second instance placed high in the address map to reach the jump vector.
  fetch_unit #(.RESET_PC(32'h3000_0000)) u_dut_hi (
    .clk(clk), .rst(rst), .cu_wpcir(1'b0), .cu_branch(h_branch),
    .cu_jump(h_jump), .imem_req(h_req), .imem_addr(h_addr),
    .imem_ack(h_ack), .imem_rdata(h_rdata), .if_instr(h_if_instr),
    .id_instr(h_instr), .id_pc4(h_pc4), .id_valid(h_valid)
  );

  // Memory with a programmable number of wait states.
  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 8'd0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 8'd1;
    else wcnt <= 8'd0;
  end
  assign imem_ack   = imem_req && (wcnt >= mem_wait);
  assign imem_rdata = mem_word(imem_addr);
  assign h_ack      = h_req;
  assign h_rdata    = mem_word(h_addr);

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every newly loaded valid ID word is popped and compared.
  always @(negedge clk) begin
    if (rst && id_valid && (!prev_valid || id_pc4 != prev_pc4)) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_valid", {31'b0, id_valid}, 32'h0);
      end else begin
        sb_exp = sb_q.pop_front();
        check_val("sb_id_pc4", id_pc4, sb_exp);
        check_val("sb_id_instr", id_instr, mem_word(sb_exp - 32'd4));
      end
    end
    prev_valid = id_valid;
    prev_pc4   = id_pc4;
  end

  initial begin
    cu_wpcir = 0; cu_branch = 0; cu_jump = 0;
    h_branch = 0; h_jump = 0; mem_wait = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", {31'b0, imem_req}, 32'h0);
    check_val("rst_addr", imem_addr, 32'h0);
    check_val("rst_id_instr", id_instr, 32'h0);
    check_val("rst_id_pc4", id_pc4, 32'h0);
    check_val("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check_val("rst_if_instr", if_instr, 32'h0);
    for (int a = 4; a <= 32'h20; a += 4) sb_q.push_back(32'(a));
    rst = 1;

    tick(); // BOOT -> REQ
    check_val("boot_req", {31'b0, imem_req}, 32'h1);
    check_val("boot_addr", imem_addr, 32'h0);
    check_val("boot_valid", {31'b0, id_valid}, 32'h0);
    tick();
    check_val("first_valid", {31'b0, id_valid}, 32'h1);
    check_val("addr_4", imem_addr, 32'h4);
    tick();
    check_val("addr_8", imem_addr, 32'h8);

    // Load-use stall while 0x8 is acked.
    cu_wpcir = 1;
    #1;
    check_val("if_instr_ack", if_instr, mem_word(32'h8));
    tick();
    check_val("hold_req", {31'b0, imem_req}, 32'h0);
    check_val("hold_id_instr", id_instr, mem_word(32'h4));
    check_val("hold_id_pc4", id_pc4, 32'h8);
    check_val("hold_if_instr", if_instr, mem_word(32'h8));
    cu_wpcir = 0;
    tick();
    check_val("unhold_id_instr", id_instr, mem_word(32'h8));
    check_val("unhold_addr", imem_addr, 32'hC);
    check_val("unhold_req", {31'b0, imem_req}, 32'h1);

    // Jump on the high instance.
    check_val("jmp_id_instr", h_instr, 32'h0800_0040);
    check_val("jmp_id_pc4", h_pc4, 32'h3000_0010);
    h_branch = 1; h_jump = 1;
    tick();
    check_val("jmp_addr", h_addr, 32'h3000_0100);
    check_val("jmp_bubble", {31'b0, h_valid}, 32'h0);
    h_branch = 0; h_jump = 0;

    // Taken beq back to 0x1C.
    repeat (4) tick();
    check_val("beq_id_instr", id_instr, 32'h1000_FFFF);
    check_val("beq_id_pc4", id_pc4, 32'h20);
    cu_branch = 1;
    tick();
    check_val("beq_addr", imem_addr, 32'h1C);
    check_val("beq_bubble", {31'b0, id_valid}, 32'h0);
    check_val("beq_bubble_instr", id_instr, 32'h0);
    cu_branch = 0;
    sb_q.push_back(32'h20);
    tick();
    check_val("beq_target_valid", {31'b0, id_valid}, 32'h1);

    // Redirect during a 3-wait-state fetch of 0x20.
    mem_wait = 8'd3;
    cu_branch = 1;
    tick();
    check_val("kill_req", {31'b0, imem_req}, 32'h1);
    check_val("kill_addr", imem_addr, 32'h20);
    check_val("kill_bubble", {31'b0, id_valid}, 32'h0);
    check_val("kill_if_instr", if_instr, 32'h0);
    cu_branch = 0;
    sb_q.push_back(32'h20);
    tick();
    check_val("kill_addr_stable", imem_addr, 32'h20);
    for (int k = 0; k < 8 && imem_addr == 32'h20; k++) tick();
    check_val("kill_next_addr", imem_addr, 32'h1C);
    check_val("kill_still_bubble", {31'b0, id_valid}, 32'h0);
    for (int k = 0; k < 10 && !id_valid; k++) tick();
    check_val("kill_wait_valid", {31'b0, id_valid}, 32'h1);
    check_val("kill_target_pc4", id_pc4, 32'h20);
    mem_wait = 8'd0;

    // Stall and branch together: stall wins, branch taken next cycle.
    cu_wpcir = 1; cu_branch = 1;
    tick();
    check_val("sb_stall_req", {31'b0, imem_req}, 32'h0);
    check_val("sb_stall_pc4", id_pc4, 32'h20);
    check_val("sb_stall_instr", id_instr, 32'h1000_FFFF);
    cu_wpcir = 0;
    tick();
    check_val("sb_branch_addr", imem_addr, 32'h1C);
    check_val("sb_branch_bubble", {31'b0, id_valid}, 32'h0);
    cu_branch = 0;
    sb_q.push_back(32'h20);
    tick();
    check_val("sb_branch_valid", {31'b0, id_valid}, 32'h1);

    // Asynchronous reset in the middle of an outstanding request.
    mem_wait = 8'd2;
    tick();
    check_val("pre_rst_req", {31'b0, imem_req}, 32'h1);
    #2;
    rst = 0;
    #1;
    check_val("arst_req", {31'b0, imem_req}, 32'h0);
    check_val("arst_h_req", {31'b0, h_req}, 32'h0);
    check_val("arst_addr", imem_addr, 32'h0);
    check_val("arst_id_instr", id_instr, 32'h0);
    check_val("arst_id_pc4", id_pc4, 32'h0);
    check_val("arst_id_valid", {31'b0, id_valid}, 32'h0);
    check_val("arst_if_instr", if_instr, 32'h0);
    check_val("sb_empty", 32'(sb_q.size()), 32'h0);
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
